// File: rtl/alu.sv
// alu: 32-bit RISC-V integer ALU. One registered result plus a zero flag,
// one cycle of latency, updating on every rising CLK edge.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       OPERATION,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_PASSB = 4'b1001,
    OP_SRA   = 4'b1101
  } alu_op_e;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;

  // Only the low bits of B steer the shifter; the rest of B is ignored.
  logic [SHW-1:0]   shamt;
  logic             lt_s, lt_u;

  // Shift amount and both compare flavours, shared by the op mux.
  always_comb begin
    shamt = B[SHW-1:0];
    lt_s  = ($signed(A) < $signed(B));
    lt_u  = (A < B);
  end

  // Next-state result: decode OPERATION; unused codes produce zero.
  always_comb begin
    result_d = '0;
    case (OPERATION)
      OP_AND:   result_d = A & B;
      OP_OR:    result_d = A | B;
      OP_ADD:   result_d = A + B;
      OP_XOR:   result_d = A ^ B;
      OP_SLL:   result_d = A << shamt;
      OP_SRL:   result_d = A >> shamt;
      OP_SUB:   result_d = A - B;
      OP_SLT:   result_d = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU:  result_d = {{(WIDTH-1){1'b0}}, lt_u};
      OP_PASSB: result_d = B;
      OP_SRA:   result_d = WIDTH'($signed(A) >>> shamt);
      default:  result_d = '0;
    endcase
    // Zero flag comes from the same next-state value so it is never stale.
    zero_d = (result_d == '0);
  end

  // Output registers; reset clears RESULT and raises ZERO immediately.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign RESULT = result_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors with hand-computed expectations for alu.
module tb_alu;

  logic        CLK;
  logic        RSTa;
  logic [31:0] A, B;
  logic [3:0]  OPERATION;
  logic [31:0] RESULT;
  logic        ZERO;

  int n_pass = 0;
  int n_tot  = 0;

  alu #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RSTa      (RSTa),
    .A         (A),
    .B         (B),
    .OPERATION (OPERATION),
    .RESULT    (RESULT),
    .ZERO      (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  // Apply inputs, clock once, sample 1ns after the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    A = a; B = b; OPERATION = op;
    @(posedge CLK);
    #1;
  endtask

  task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input logic [31:0] exp);
    step(a, b, op);
    chk(tag, RESULT, exp);
    chk({tag, "_z"}, {31'b0, ZERO}, {31'b0, exp == 32'h0});
  endtask

  initial begin
    RSTa = 1'b1; A = 32'hFFFF_FFFF; B = 32'h1234_5678; OPERATION = 4'b0001;
    #1 RSTa = 1'b0;
    #1;
    chk("rst_res", RESULT, 32'h0);
    chk("rst_zero", {31'b0, ZERO}, 32'h1);
    @(negedge CLK);
    RSTa = 1'b1;

    vec("post_rst", 32'h0, 32'h0, 4'b0000, 32'h0);

    // Logic ops
    vec("and", 32'h0000_00EC, 32'h0000_0258, 4'b0000, 32'h0000_0048);
    vec("or",  32'h0000_00EC, 32'h0000_0258, 4'b0001, 32'h0000_02FC);
    vec("xor", 32'h0000_00EC, 32'h0000_0258, 4'b0011, 32'h0000_02B4);

    // Shifts and undefined code
    vec("sll24", 32'h0000_00EC, 32'h0000_0258, 4'b0100, 32'hEC00_0000);
    vec("op1111", 32'h0000_00EC, 32'h0000_0258, 4'b1111, 32'h0);
    vec("srl4", 32'h8000_0000, 32'h0000_0004, 4'b0101, 32'h0800_0000);
    vec("sra4", 32'h8000_0000, 32'h0000_0004, 4'b1101, 32'hF800_0000);
    vec("sra_b32", 32'h8000_0001, 32'h0000_0020, 4'b1101, 32'h8000_0001);
    vec("sll31", 32'h0000_0001, 32'hFFFF_FFFF, 4'b0100, 32'h8000_0000);
    vec("srl31", 32'hFFFF_FFFF, 32'h0000_001F, 4'b0101, 32'h0000_0001);

    // Arithmetic
    vec("add", 32'h0000_01C4, 32'h0001_5B41, 4'b0010, 32'h0001_5D05);
    vec("sub", 32'h0000_01C4, 32'h0001_5B41, 4'b0110, 32'hFFFE_A683);
    vec("sub_eq", 32'd5, 32'd5, 4'b0110, 32'h0);
    vec("add_wrap", 32'hFFFF_FFFF, 32'h1, 4'b0010, 32'h0);

    // Compares and pass-through
    vec("slt_gt", 32'd100, 32'd26, 4'b0111, 32'h0);
    vec("slt_neg", 32'hFFFF_FFFF, 32'h1, 4'b0111, 32'h1);
    vec("sltu_big", 32'hFFFF_FFFF, 32'h1, 4'b1000, 32'h0);
    vec("sltu_lt", 32'h1, 32'hFFFF_FFFF, 4'b1000, 32'h1);
    vec("slt_eq", 32'h8000_0000, 32'h8000_0000, 4'b0111, 32'h0);
    vec("passb", 32'hDEAD_BEEF, 32'h1234_5000, 4'b1001, 32'h1234_5000);

    // Remaining unused codes all give zero
    vec("op1010", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1010, 32'h0);
    vec("op1011", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1011, 32'h0);
    vec("op1100", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100, 32'h0);
    vec("op1110", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1110, 32'h0);

    // Latency: outputs hold between edges while inputs change
    vec("lat_load", 32'h0000_00EC, 32'h0000_0258, 4'b0001, 32'h0000_02FC);
    #2 A = 32'h0; OPERATION = 4'b0000;
    #2;
    chk("lat_hold", RESULT, 32'h0000_02FC);
    chk("lat_hold_z", {31'b0, ZERO}, 32'h0);
    @(posedge CLK); #1;
    chk("lat_next", RESULT, 32'h0);
    chk("lat_next_z", {31'b0, ZERO}, 32'h1);

    // Mid-cycle reset clears at once and overrides the next edge
    vec("pre_rst", 32'hA5A5_0000, 32'h0000_5A5A, 4'b0001, 32'hA5A5_5A5A);
    #2 RSTa = 1'b0;
    #1;
    chk("mid_rst", RESULT, 32'h0);
    chk("mid_rst_z", {31'b0, ZERO}, 32'h1);
    @(posedge CLK); #1;
    chk("rst_held", RESULT, 32'h0);
    @(negedge CLK);
    RSTa = 1'b1;
    #1;
    chk("rel_noedge", RESULT, 32'h0);
    @(posedge CLK); #1;
    chk("rel_load", RESULT, 32'hA5A5_5A5A);
    chk("rel_load_z", {31'b0, ZERO}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
